// File: rtl/riscv_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
// No ports; imported by fetch_fifo and riscv_fetch_unit.
package riscv_fetch_pkg;

    localparam int          INST_BYTES         = 4;
    localparam logic [31:0] RV_NOP             = 32'h0000_0013;
    localparam int          DEFAULT_FIFO_DEPTH = 4;
    localparam int          FIFO_PTR_W         = $clog2(DEFAULT_FIFO_DEPTH);

    // Clears the byte-offset bits so every PC is word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             drop all entries and reset pointers (wins over push/pop)
//   push, wdata       write one entry
//   pop               advance the head (ignored when empty)
//   rdata             head entry; when empty, holds the last popped entry
//   count, full, empty occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    // A push into a full buffer is accepted only if the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues requests to a 1-cycle
// synchronous instruction memory and buffers {word, pc} pairs for decode.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   imem_en, imem_addr         fetch request / byte address (= pc)
//   imem_rdata                 read data, valid the cycle after imem_en
//   redirect_valid/_target     taken branch or jump; flushes and reloads pc
//   inst_valid/_ready          decode handshake: a transfer happens on a cycle
//                              where both are high; inst_valid never depends
//                              on inst_ready
//   inst_data, inst_pc         head instruction and its PC
//   perf_fetches/perf_flushes  saturating counters (only with FETCH_PERF_EN)
// Optional feature macro: FETCH_PERF_EN.
// ADDR_WIDTH is limited to 32 by align_pc.
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]           perf_fetches,
    output logic [15:0]           perf_flushes
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FW    = DATA_WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] tag;
    logic                  inflight;
    logic                  kill;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic [CNT_W:0]        credits;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [FW-1:0]         head;

    // The outstanding response already owns a slot, so it is counted as used.
    assign credits = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue   = !rst && !redirect_valid && !full
                     && (credits < (CNT_W + 1)'(FIFO_DEPTH));
    // A redirect in the response cycle drops the returning word as well.
    assign push    = inflight && !kill && !redirect_valid;
    assign pop     = !empty && inst_ready && !redirect_valid;

    assign imem_en    = issue;
    assign imem_addr  = pc;
    assign inst_valid = !empty;
    assign inst_data  = head[FW-1:ADDR_WIDTH];
    assign inst_pc    = head[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= ADDR_WIDTH'(RESET_PC);
            tag      <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            inflight <= issue;
            kill     <= redirect_valid;
            if (redirect_valid) begin
                pc <= ADDR_WIDTH'(align_pc(32'(redirect_target)));
            end else if (issue) begin
                pc  <= pc + ADDR_WIDTH'(INST_BYTES);
                tag <= pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({imem_rdata, tag}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetches <= '0;
            perf_flushes <= '0;
        end else begin
            if (issue && perf_fetches != 16'hFFFF) begin
                perf_fetches <= perf_fetches + 16'd1;
            end
            if (redirect_valid && perf_flushes != 16'hFFFF) begin
                perf_flushes <= perf_flushes + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed, table-driven bench for riscv_fetch_unit (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_riscv_fetch_unit;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_target = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [15:0]   perf_fetches;
    logic [15:0]   perf_flushes;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic          ready;
        logic          redir;
        logic [AW-1:0] tgt;
        logic          ev;
        logic [AW-1:0] epc;
        logic          een;
        logic [AW-1:0] eaddr;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (4),
        .RESET_PC   (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_en         (imem_en),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetches    (perf_fetches),
        .perf_flushes    (perf_flushes)
`endif
    );

    // Memory content derived from the address, so each word identifies its PC.
    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {16'hC0DE, 8'h00, a};
    endfunction

    always_ff @(posedge clk) begin
        if (imem_en) begin
            imem_rdata <= word(imem_addr);
        end
    end

    task automatic add(input logic ready, input logic redir, input logic [AW-1:0] tgt,
                       input logic ev, input logic [AW-1:0] epc,
                       input logic een, input logic [AW-1:0] eaddr);
        vec_t v;
        v.ready = ready; v.redir = redir; v.tgt = tgt;
        v.ev = ev; v.epc = epc; v.een = een; v.eaddr = eaddr;
        tbl.push_back(v);
    endtask

    task automatic check1(input string name, input int idx, input logic [DW-1:0] got,
                          input logic [DW-1:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s (step %0d): got %h, want %h", name, idx, got, want);
        end
    endtask

    // Apply one cycle of inputs, compare, then advance to the next falling edge.
    task automatic apply(input vec_t v, input int idx);
        inst_ready      = v.ready;
        redirect_valid  = v.redir;
        redirect_target = v.tgt;
        #1;
        vectors++;
        check1("inst_valid", idx, DW'(inst_valid), DW'(v.ev));
        check1("imem_en", idx, DW'(imem_en), DW'(v.een));
        check1("imem_addr", idx, DW'(imem_addr), DW'(v.eaddr));
        if (v.ev) begin
            check1("inst_pc", idx, DW'(inst_pc), DW'(v.epc));
            check1("inst_data", idx, inst_data, word(v.epc));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input int idx);
        vectors++;
        check1("rst inst_valid", idx, DW'(inst_valid), '0);
        check1("rst imem_en", idx, DW'(imem_en), '0);
        check1("rst imem_addr", idx, DW'(imem_addr), '0);
        check1("rst inst_data", idx, inst_data, '0);
        check1("rst inst_pc", idx, DW'(inst_pc), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_fetches;
        int exp_flushes;

        // Fill, stall with ready low, drain, redirect with 3 buffered,
        // redirect together with a pop, PC wrap, back-to-back redirects.
        //  ready redir tgt    ev  epc   een addr
        add(1, 0, 8'h00,  0, 8'h00, 1, 8'h00);
        add(1, 0, 8'h00,  0, 8'h00, 1, 8'h04);
        add(1, 0, 8'h00,  1, 8'h00, 1, 8'h08);
        add(1, 0, 8'h00,  1, 8'h04, 1, 8'h0c);
        add(1, 0, 8'h00,  1, 8'h08, 1, 8'h10);
        add(0, 0, 8'h00,  1, 8'h0c, 1, 8'h14);
        add(0, 0, 8'h00,  1, 8'h0c, 1, 8'h18);
        add(0, 0, 8'h00,  1, 8'h0c, 0, 8'h1c);
        add(0, 0, 8'h00,  1, 8'h0c, 0, 8'h1c);
        add(0, 0, 8'h00,  1, 8'h0c, 0, 8'h1c);
        add(0, 0, 8'h00,  1, 8'h0c, 0, 8'h1c);
        add(1, 0, 8'h00,  1, 8'h0c, 0, 8'h1c);
        add(1, 0, 8'h00,  1, 8'h10, 1, 8'h1c);
        add(1, 0, 8'h00,  1, 8'h14, 1, 8'h20);
        add(1, 0, 8'h00,  1, 8'h18, 1, 8'h24);
        add(1, 0, 8'h00,  1, 8'h1c, 1, 8'h28);
        add(0, 0, 8'h00,  1, 8'h20, 1, 8'h2c);
        add(0, 1, 8'h43,  1, 8'h20, 0, 8'h30);
        add(1, 0, 8'h00,  0, 8'h00, 1, 8'h40);
        add(1, 0, 8'h00,  0, 8'h00, 1, 8'h44);
        add(1, 1, 8'h80,  1, 8'h40, 0, 8'h48);
        add(1, 0, 8'h00,  0, 8'h00, 1, 8'h80);
        add(1, 0, 8'h00,  0, 8'h00, 1, 8'h84);
        add(1, 1, 8'hF8,  1, 8'h80, 0, 8'h88);
        add(1, 0, 8'h00,  0, 8'h00, 1, 8'hF8);
        add(1, 0, 8'h00,  0, 8'h00, 1, 8'hFC);
        add(1, 0, 8'h00,  1, 8'hF8, 1, 8'h00);
        add(1, 0, 8'h00,  1, 8'hFC, 1, 8'h04);
        add(1, 1, 8'h10,  1, 8'h00, 0, 8'h08);
        add(1, 1, 8'h22,  0, 8'h00, 0, 8'h10);
        add(1, 0, 8'h00,  0, 8'h00, 1, 8'h20);
        add(1, 0, 8'h00,  0, 8'h00, 1, 8'h24);
        add(0, 0, 8'h00,  1, 8'h20, 1, 8'h28);
        add(0, 0, 8'h00,  1, 8'h20, 1, 8'h2c);

        // Reset state while rst is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs(-1);
`ifdef FETCH_PERF_EN
        check1("rst perf_fetches", -1, DW'(perf_fetches), '0);
        check1("rst perf_flushes", -1, DW'(perf_flushes), '0);
`endif
        #1;
        rst = 1'b0;

        exp_fetches = 0;
        exp_flushes = 0;
        foreach (tbl[i]) begin
            apply(tbl[i], i);
            exp_fetches += int'(tbl[i].een);
            exp_flushes += int'(tbl[i].redir);
        end

`ifdef FETCH_PERF_EN
        vectors++;
        check1("perf_fetches", -2, DW'(perf_fetches), DW'(exp_fetches));
        check1("perf_flushes", -2, DW'(perf_flushes), DW'(exp_flushes));
`endif

        // Asynchronous reset mid-run, with entries buffered and a fetch in flight.
        inst_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(-3);
`ifdef FETCH_PERF_EN
        check1("midrst perf_fetches", -3, DW'(perf_fetches), '0);
        check1("midrst perf_flushes", -3, DW'(perf_flushes), '0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Refill from RESET_PC: same 2-cycle latency as the first release.
        tbl.delete();
        add(1, 0, 8'h00, 0, 8'h00, 1, 8'h00);
        add(1, 0, 8'h00, 0, 8'h00, 1, 8'h04);
        add(1, 0, 8'h00, 1, 8'h00, 1, 8'h08);
        add(1, 0, 8'h00, 1, 8'h04, 1, 8'h0c);
        foreach (tbl[i]) begin
            apply(tbl[i], 100 + i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
